ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port scratch RAM between two requesters: the DMA engine (write bursts of decompressed rows or CPU data) and the CNN core (read bursts of image/filter words).
- Sits between DMA/CNN and the RAM instance inside the IO unit.
- Issues one RAM access per cycle, generates incrementing burst addresses, arbitrates round-robin, and returns read data with fixed latency.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 16, RAM word width (equals sectionSize).
- LEN_W, 6, burst-length field width; max burst 2^LEN_W - 1 beats.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- dma_req  in  1  DMA requests a write burst; held until dma_done or abort.
- dma_addr  in  ADDR_W  DMA burst base address; sampled at grant.
- dma_len  in  LEN_W  DMA burst length in beats; sampled at grant.
- dma_wdata  in  DATA_W  write data for the current beat.
- dma_gnt  out  1  DMA owns the RAM (high for the whole burst).
- dma_ack  out  1  current dma_wdata consumed this cycle; requester advances.
- dma_done  out  1  one-cycle pulse on the last DMA beat.
- cnn_req  in  1  CNN requests a read burst.
- cnn_addr  in  ADDR_W  CNN burst base address; sampled at grant.
- cnn_len  in  LEN_W  CNN burst length.
- cnn_gnt  out  1  CNN owns the RAM.
- cnn_rdata  out  DATA_W  read data.
- cnn_rvalid  out  1  cnn_rdata valid this cycle.
- cnn_done  out  1  one-cycle pulse on the last CNN address beat.
- ram_enable  out  1  RAM access this cycle.
- ram_write  out  1  1 = write, 0 = read.
- ram_address  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data (combinational pass of dma_wdata while DMA owns).
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read enable.

Behaviour:
- FSM states: IDLE, DMA_BURST, CNN_BURST.
- Registers: base address, beat counter (LEN_W), latched length, last_owner (1 bit), rvalid pipeline flag.
- Reset (rst low, async):
  - state IDLE, last_owner = CNN, so DMA wins the first tie.
  - All outputs 0; ram_wdata and cnn_rdata 0.
  - rvalid pipeline cleared; a read in flight is dropped.
- IDLE arbitration:
  - Only one requester high: grant it.
  - Both high: grant the one that is not last_owner.
  - On grant, latch addr/len and clear the counter; next cycle enters the burst state.
  - Latency: req sampled at edge T, gnt and first ram_enable asserted in cycle T+1.
- Burst beat (every cycle in a burst state):
  - ram_enable = 1; ram_address = base + counter, modulo 2^ADDR_W (wrap silently past top of memory).
  - DMA: ram_write = 1, dma_ack = 1.
  - CNN: ram_write = 0; cnn_rvalid = 1 and cnn_rdata = ram_rdata one cycle after each read beat (registered).
- len = 0 is treated as 1 beat.
- Last beat (counter == len-1, or beat 0 when len = 0):
  - Pulse done in the same cycle as that beat.
  - Update last_owner; next state IDLE.
  - gnt drops after the last beat.
  - Mandatory one-cycle IDLE bubble between bursts, including back-to-back bursts by the same requester.
- Abort: the owner's req sampled low mid-burst:
  - No RAM access in that cycle; no done pulse.
  - Return to IDLE; last_owner still updated.
  - For CNN, the rvalid for the previous beat is still delivered.
- cnn_rvalid for the final CNN beat appears in the IDLE bubble cycle after cnn_done.
- No preemption: a requester waits at most one maximum-length burst plus one bubble.
- Outputs in IDLE: gnt/ack/ram_enable/ram_write 0; ram_address holds 0.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE = 2'd0, DMA_BURST = 2'd1, CNN_BURST = 2'd2).
  - Owner encoding (OWN_DMA = 0, OWN_CNN = 1).
  - Default widths ADDR_W/DATA_W/LEN_W, shared with DMA and RAM.
- One sub-module, burst_addr_gen: latches base/len, runs the counter, outputs address, last flag and done.
- Arbitration FSM and read-valid pipeline stay in the top module.

Test Plan:
1. Reset mid-burst: DMA burst len 8 at beat 3, assert rst low -> all outputs 0 immediately; after release, IDLE and no done pulse.
2. DMA solo write: dma_req, addr 0x0100, len 4, wdata 0xA0..0xA3 -> gnt in cycle T+1; ram writes 0x0100..0x0103 with matching data; dma_ack high 4 cycles; dma_done on 4th beat; gnt low after.
3. CNN read latency: memory preloaded 0x11,0x22,0x33 at 0x0020, cnn_len 3 -> cnn_rvalid in 3 consecutive cycles starting one cycle after first ram_enable; data 0x11,0x22,0x33; cnn_done coincides with third address beat.
4. Tie and round-robin: both req high from reset, len 2 each, held -> order DMA, CNN, DMA, CNN; exactly one idle cycle between each burst.
5. Wrap and len 0: CNN addr 0xFFFE, len 3 -> addresses 0xFFFE, 0xFFFF, 0x0000. DMA len 0 -> exactly one write beat plus dma_done.
6. Abort: CNN len 10, drop cnn_req after 4th beat -> 4 read beats, 4 rvalids, no cnn_done; a pending dma_req is granted after one bubble.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default widths for the scratch-RAM arbiter and its neighbours.
package ram_arbiter_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LEN_W  = 6;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StDmaBurst = 2'd1,
      StCnnBurst = 2'd2
   } state_e;

   typedef enum logic {
      OwnDma = 1'b0,
      OwnCnn = 1'b1
   } owner_e;

   // DMA wins if it is the only requester, or on a tie when CNN owned last.
   function automatic logic pick_dma(logic dma_req, logic cnn_req, owner_e last_owner);
      return dma_req && (!cnn_req || (last_owner == OwnCnn));
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// DMA, CNN and RAM-side signals of the scratch-RAM arbiter.
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ram_arbiter_pkg::ADDR_W,
   parameter int unsigned DATA_W = ram_arbiter_pkg::DATA_W,
   parameter int unsigned LEN_W  = ram_arbiter_pkg::LEN_W
) ();

   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [LEN_W-1:0]  dma_len;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_ack;
   logic              dma_done;

   logic              cnn_req;
   logic [ADDR_W-1:0] cnn_addr;
   logic [LEN_W-1:0]  cnn_len;
   logic              cnn_gnt;
   logic [DATA_W-1:0] cnn_rdata;
   logic              cnn_rvalid;
   logic              cnn_done;

   logic              ram_enable;
   logic              ram_write;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  dma_req, dma_addr, dma_len, dma_wdata,
      input  cnn_req, cnn_addr, cnn_len,
      input  ram_rdata,
      output dma_gnt, dma_ack, dma_done,
      output cnn_gnt, cnn_rdata, cnn_rvalid, cnn_done,
      output ram_enable, ram_write, ram_address, ram_wdata
   );

   modport master (
      output dma_req, dma_addr, dma_len, dma_wdata,
      output cnn_req, cnn_addr, cnn_len,
      output ram_rdata,
      input  dma_gnt, dma_ack, dma_done,
      input  cnn_gnt, cnn_rdata, cnn_rvalid, cnn_done,
      input  ram_enable, ram_write, ram_address, ram_wdata
   );

endinterface

// File: rtl/ram_arbiter_burst_addr_gen.sv
// Burst address generator: latches base/length at grant and steps one word per beat.
module burst_addr_gen
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ram_arbiter_pkg::ADDR_W,
   parameter int unsigned LEN_W  = ram_arbiter_pkg::LEN_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              beat_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o,
   output logic              done_o
);

   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         base_d = base_i;
         len_d  = len_i;
         cnt_d  = '0;
      end else if (beat_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         cnt_q  <= cnt_d;
      end
   end

   // Address wraps modulo 2^ADDR_W; a zero length behaves as a single beat.
   assign addr_o = base_q + ADDR_W'(cnt_q);
   assign last_o = (len_q == '0) || (cnt_q == len_q - 1'b1);
   assign done_o = beat_i && last_o;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port scratch RAM between DMA writes and CNN reads.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ram_arbiter_pkg::ADDR_W,
   parameter int unsigned DATA_W = ram_arbiter_pkg::DATA_W,
   parameter int unsigned LEN_W  = ram_arbiter_pkg::LEN_W
) (
   input  logic          clk,
   input  logic          rst,
   ram_arbiter_if.slave  bus
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              rvalid_q, rvalid_d;

   logic              dma_own, cnn_own;
   logic              dma_win, cnn_win;
   logic              load, beat, abort, last, done;
   logic [ADDR_W-1:0] addr, base_sel;
   logic [LEN_W-1:0]  len_sel;
   logic [DATA_W-1:0] rdata_gated;

   always_comb begin
      dma_own  = (state_q == StDmaBurst);
      cnn_own  = (state_q == StCnnBurst);
      dma_win  = (state_q == StIdle) && pick_dma(bus.dma_req, bus.cnn_req, owner_q);
      cnn_win  = (state_q == StIdle) && bus.cnn_req && !dma_win;
      load     = dma_win || cnn_win;
      base_sel = dma_win ? bus.dma_addr : bus.cnn_addr;
      len_sel  = dma_win ? bus.dma_len : bus.cnn_len;
      // The owner dropping its request ends the burst without touching the RAM.
      beat     = (dma_own && bus.dma_req) || (cnn_own && bus.cnn_req);
      abort    = (dma_own || cnn_own) && !beat;
   end

   burst_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk_i  (clk),
      .rst_ni (rst),
      .load_i (load),
      .base_i (base_sel),
      .len_i  (len_sel),
      .beat_i (beat),
      .addr_o (addr),
      .last_o (last),
      .done_o (done)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rvalid_d = cnn_own && bus.cnn_req;
      unique case (state_q)
         StIdle: begin
            if (dma_win) begin
               state_d = StDmaBurst;
            end else if (cnn_win) begin
               state_d = StCnnBurst;
            end
         end
         StDmaBurst: begin
            if (abort || (beat && last)) begin
               state_d = StIdle;
               owner_d = OwnDma;
            end
         end
         StCnnBurst: begin
            if (abort || (beat && last)) begin
               state_d = StIdle;
               owner_d = OwnCnn;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         owner_q  <= OwnCnn;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rvalid_q <= rvalid_d;
      end
   end

   // RAM data arrives the cycle after the read enable, alongside rvalid_q.
   assign rdata_gated     = rvalid_q ? bus.ram_rdata : '0;

   assign bus.dma_gnt     = dma_own;
   assign bus.dma_ack     = dma_own && bus.dma_req;
   assign bus.dma_done    = dma_own && done;
   assign bus.cnn_gnt     = cnn_own;
   assign bus.cnn_done    = cnn_own && done;
   assign bus.cnn_rvalid  = rvalid_q;
   assign bus.cnn_rdata   = rdata_gated;
   assign bus.ram_enable  = beat;
   assign bus.ram_write   = dma_own && bus.dma_req;
   assign bus.ram_address = beat ? addr : '0;
   assign bus.ram_wdata   = dma_own ? bus.dma_wdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: requester models, a behavioural RAM and per-beat checks.
module tb_ram_arbiter;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ram_arbiter_if bus ();

   ram_arbiter u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t       dma_exp[$];
   beat_t       cnn_exp[$];
   logic [15:0] rd_exp[$];
   int          d_cyc[$];
   int          c_cyc[$];
   int          v_cyc[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        prev_done = 1'b0;
   beat_t       e;
   logic [15:0] mem [int];

   function automatic logic [15:0] word_at(input logic [15:0] a);
      case (a)
         16'h0020: return 16'h0011;
         16'h0021: return 16'h0022;
         16'h0022: return 16'h0033;
         default:  return a ^ 16'h5A5A;
      endcase
   endfunction

   function automatic int at(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      d_cyc.delete();
      c_cyc.delete();
      v_cyc.delete();
   endtask

   task automatic zero_check(input string pfx);
      check({pfx, "_dma"}, 32'({bus.dma_gnt, bus.dma_ack, bus.dma_done}), 32'd0);
      check({pfx, "_cnn"}, 32'({bus.cnn_gnt, bus.cnn_rvalid, bus.cnn_done}), 32'd0);
      check({pfx, "_ram_ctl"}, 32'({bus.ram_enable, bus.ram_write}), 32'd0);
      check({pfx, "_ram_addr"}, 32'(bus.ram_address), 32'd0);
      check({pfx, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
      check({pfx, "_cnn_rdata"}, 32'(bus.cnn_rdata), 32'd0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.ram_enable) begin
         if (bus.ram_write) begin
            mem[int'(bus.ram_address)] = bus.ram_wdata;
         end else begin
            bus.ram_rdata <= mem.exists(int'(bus.ram_address)) ?
                             mem[int'(bus.ram_address)] : word_at(bus.ram_address);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (bus.ram_enable) begin
            if (bus.ram_write) begin
               d_cyc.push_back(cyc);
               if (dma_exp.size() == 0) begin
                  check("dma_extra_beat", 32'd1, 32'd0);
               end else begin
                  e = dma_exp.pop_front();
                  check("dma_addr", 32'(bus.ram_address), 32'(e.addr));
                  check("dma_wdata", 32'(bus.ram_wdata), 32'(e.data));
                  check("dma_flags", 32'({bus.dma_gnt, bus.dma_ack, bus.dma_done, bus.cnn_done}),
                        32'({1'b1, 1'b1, e.last, 1'b0}));
               end
            end else begin
               c_cyc.push_back(cyc);
               if (cnn_exp.size() == 0) begin
                  check("cnn_extra_beat", 32'd1, 32'd0);
               end else begin
                  e = cnn_exp.pop_front();
                  check("cnn_addr", 32'(bus.ram_address), 32'(e.addr));
                  check("cnn_flags", 32'({bus.cnn_gnt, bus.cnn_done, bus.dma_ack, bus.dma_done}),
                        32'({1'b1, e.last, 1'b0, 1'b0}));
               end
            end
         end else begin
            check("idle_quiet", 32'({bus.dma_ack, bus.ram_write, bus.dma_done, bus.cnn_done}),
                  32'd0);
            check("idle_addr", 32'(bus.ram_address), 32'd0);
         end
         if (prev_done) begin
            check("bubble_after_done", 32'({bus.ram_enable, bus.dma_gnt, bus.cnn_gnt}), 32'd0);
         end
         prev_done = bus.dma_done || bus.cnn_done;
         if (bus.cnn_rvalid) begin
            v_cyc.push_back(cyc);
            if (rd_exp.size() == 0) begin
               check("cnn_extra_rvalid", 32'd1, 32'd0);
            end else begin
               check("cnn_rdata", 32'(bus.cnn_rdata), 32'(rd_exp.pop_front()));
            end
         end
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic dma_run(input logic [15:0] addr, input logic [5:0] len, input int nb,
                          input logic [15:0] wbase, output int req_cyc);
      int   n, b, i, t;
      logic acked;
      n = (len == 0) ? 1 : int'(len);
      for (int bb = 0; bb < nb; bb++) begin
         for (int k = 0; k < n; k++) begin
            dma_exp.push_back('{addr: addr + 16'(16 * bb + k), data: wbase + 16'(16 * bb + k),
                                last: (k == n - 1)});
         end
      end
      bus.dma_addr  = addr;
      bus.dma_len   = len;
      bus.dma_wdata = wbase;
      bus.dma_req   = 1'b1;
      req_cyc = cyc;
      b = 0;
      i = 0;
      t = 0;
      while (b < nb && t < 500) begin
         @(negedge clk);
         t++;
         acked = bus.dma_ack;
         @(posedge clk);
         #1;
         if (acked) begin
            if (i == n - 1) begin
               i = 0;
               b++;
               if (b == nb) bus.dma_req = 1'b0;
               else bus.dma_addr = addr + 16'(16 * b);
            end else begin
               i++;
            end
         end
         bus.dma_wdata = wbase + 16'(16 * b + i);
      end
      if (b < nb) begin
         check("dma_timeout", 32'(b), 32'(nb));
         bus.dma_req = 1'b0;
      end
   endtask

   task automatic cnn_run(input logic [15:0] addr, input logic [5:0] len, input int nb,
                          input int abort_after, output int req_cyc);
      int   n, nbeat, b, i, t;
      logic hit;
      n = (len == 0) ? 1 : int'(len);
      nbeat = (abort_after > 0) ? abort_after : n;
      for (int bb = 0; bb < nb; bb++) begin
         for (int k = 0; k < nbeat; k++) begin
            cnn_exp.push_back('{addr: addr + 16'(16 * bb + k), data: 16'h0,
                                last: (abort_after == 0 && k == n - 1)});
            rd_exp.push_back(word_at(addr + 16'(16 * bb + k)));
         end
      end
      bus.cnn_addr = addr;
      bus.cnn_len  = len;
      bus.cnn_req  = 1'b1;
      req_cyc = cyc;
      b = 0;
      i = 0;
      t = 0;
      while (b < nb && t < 500) begin
         @(negedge clk);
         t++;
         hit = bus.cnn_gnt && bus.ram_enable && !bus.ram_write;
         @(posedge clk);
         #1;
         if (hit) begin
            if (abort_after > 0 && i + 1 == abort_after) begin
               bus.cnn_req = 1'b0;
               b = nb;
            end else if (i == n - 1) begin
               i = 0;
               b++;
               if (b == nb) bus.cnn_req = 1'b0;
               else bus.cnn_addr = addr + 16'(16 * b);
            end else begin
               i++;
            end
         end
      end
      if (b < nb) begin
         check("cnn_timeout", 32'(b), 32'(nb));
         bus.cnn_req = 1'b0;
      end
   endtask

   initial begin : main
      int rc, rc2, acks, t, c0, cl;
      bus.dma_req   = 1'b0;
      bus.dma_addr  = '0;
      bus.dma_len   = '0;
      bus.dma_wdata = '0;
      bus.cnn_req   = 1'b0;
      bus.cnn_addr  = '0;
      bus.cnn_len   = '0;
      #3;
      zero_check("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);

      // Reset in the middle of a DMA burst.
      for (int k = 0; k < 8; k++) begin
         dma_exp.push_back('{addr: 16'(16'h0080 + k), data: 16'hBEEF, last: (k == 7)});
      end
      bus.dma_addr  = 16'h0080;
      bus.dma_len   = 6'd8;
      bus.dma_wdata = 16'hBEEF;
      bus.dma_req   = 1'b1;
      acks = 0;
      t = 0;
      while (acks < 3 && t < 100) begin
         @(negedge clk);
         if (bus.dma_ack) acks++;
         t++;
      end
      check("t1_acks", 32'(acks), 32'd3);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      zero_check("t1_rst");
      dma_exp.delete();
      bus.dma_req = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      clear_logs();
      idle(4);
      check("t1_no_beats", 32'(d_cyc.size()), 32'd0);
      check("t1_gnt", 32'({bus.dma_gnt, bus.cnn_gnt}), 32'd0);

      // DMA solo write burst.
      clear_logs();
      dma_run(16'h0100, 6'd4, 1, 16'h00A0, rc);
      idle(3);
      check("t2_beats", 32'(d_cyc.size()), 32'd4);
      check("t2_latency", 32'(at(d_cyc, 0)), 32'(rc + 1));
      check("t2_contig", 32'(at(d_cyc, 3)), 32'(rc + 4));

      // CNN read burst and read-data latency.
      clear_logs();
      cnn_run(16'h0020, 6'd3, 1, 0, rc);
      idle(3);
      c0 = at(c_cyc, 0);
      check("t3_beats", 32'(c_cyc.size()), 32'd3);
      check("t3_latency", 32'(c0), 32'(rc + 1));
      check("t3_rvalids", 32'(v_cyc.size()), 32'd3);
      for (int k = 0; k < 3; k++) check("t3_rvalid_cyc", 32'(at(v_cyc, k)), 32'(c0 + 1 + k));

      // Tie from reset, both held: DMA, CNN, DMA, CNN with one-cycle bubbles.
      clear_logs();
      rst = 1'b0;
      fork
         dma_run(16'h0140, 6'd2, 2, 16'h00C0, rc);
         cnn_run(16'h0500, 6'd2, 2, 0, rc2);
         begin
            idle(2);
            rst = 1'b1;
         end
      join
      idle(3);
      c0 = at(d_cyc, 0);
      check("t4_dma_beats", 32'(d_cyc.size()), 32'd4);
      check("t4_cnn_beats", 32'(c_cyc.size()), 32'd4);
      check("t4_d1", 32'(at(d_cyc, 1) - c0), 32'd1);
      check("t4_d2", 32'(at(d_cyc, 2) - c0), 32'd6);
      check("t4_d3", 32'(at(d_cyc, 3) - c0), 32'd7);
      check("t4_c0", 32'(at(c_cyc, 0) - c0), 32'd3);
      check("t4_c1", 32'(at(c_cyc, 1) - c0), 32'd4);
      check("t4_c2", 32'(at(c_cyc, 2) - c0), 32'd9);
      check("t4_c3", 32'(at(c_cyc, 3) - c0), 32'd10);

      // Address wrap on CNN, zero-length DMA burst.
      clear_logs();
      cnn_run(16'hFFFE, 6'd3, 1, 0, rc);
      dma_run(16'h0300, 6'd0, 1, 16'h00E0, rc2);
      idle(3);
      check("t5_cnn_beats", 32'(c_cyc.size()), 32'd3);
      check("t5_dma_beats", 32'(d_cyc.size()), 32'd1);

      // CNN abort after 4 beats with a DMA request pending.
      clear_logs();
      fork
         cnn_run(16'h0400, 6'd10, 1, 4, rc);
         begin
            t = 0;
            while (!bus.cnn_gnt && t < 50) begin
               @(posedge clk);
               #1;
               t++;
            end
            check("t6_cnn_gnt", 32'(bus.cnn_gnt), 32'd1);
            dma_run(16'h0200, 6'd2, 1, 16'h00D0, rc2);
         end
      join
      idle(3);
      cl = at(c_cyc, 3);
      check("t6_cnn_beats", 32'(c_cyc.size()), 32'd4);
      check("t6_rvalids", 32'(v_cyc.size()), 32'd4);
      check("t6_dma_beats", 32'(d_cyc.size()), 32'd2);
      check("t6_dma_wait_ok",
            32'((at(d_cyc, 0) - cl >= 2) && (at(d_cyc, 0) - cl <= 3)), 32'd1);

      check("dma_exp_left", 32'(dma_exp.size()), 32'd0);
      check("cnn_exp_left", 32'(cnn_exp.size()), 32'd0);
      check("rd_exp_left", 32'(rd_exp.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
